// File: rtl/chess_pkg.sv
// Shared chess types for the FEN position path: piece/square codes, board image, load errors.
package chess_pkg;
  localparam int NUM_SQ = 64;

  typedef logic [3:0]   piece_t;
  typedef logic [5:0]   sq_t;
  typedef logic [255:0] board_t;

  localparam piece_t PIECE_EMPTY = 4'd0;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SHORT   = 2'd1,
    ERR_LONG    = 2'd2,
    ERR_SOP_MID = 2'd3
  } fen_err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DROP
  } ld_state_t;

  // FEN walks a8..h8 then down to h1; flipping the rank bits maps it to a1 = 0.
  function automatic sq_t beat_to_sq(input sq_t beat);
    return beat ^ 6'd56;
  endfunction
endpackage

// File: rtl/board_regfile.sv
// 64x4 shadow board with one write port and a bulk snapshot that already includes
// the write in flight, so a commit on the final beat captures that beat too.
module board_regfile
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [5:0]   wr_sq,
  input  logic [3:0]   wr_data,
  output logic [255:0] snap
);
  board_t shadow;

  always_ff @(posedge clk) begin
    if (rst) shadow <= '0;
    else if (wr_en) shadow[{wr_sq, 2'b00} +: 4] <= wr_data;
  end

  always_comb begin
    snap = shadow;
    if (wr_en) snap[{wr_sq, 2'b00} +: 4] = wr_data;
  end
endmodule

// File: rtl/fen_board_load.sv
// Collects one FEN piece stream into a shadow board and commits it atomically on a
// well-formed packet; flags short/long/restarted packets and serves a registered square read.
module fen_board_load
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [3:0]   in_data,
  input  logic         in_sop,
  input  logic         in_eop,
  output logic [255:0] o_board,
  output logic         o_board_valid,
  output logic         o_err,
  output logic [1:0]   o_err_code,
  output logic         o_busy,
  input  logic [5:0]   i_sq_addr,
  output logic [3:0]   o_sq_piece
);
  ld_state_t state, state_n;
  logic [6:0] count, count_n;
  logic       wr_en, commit, err;
  sq_t        wr_sq;
  fen_err_t   err_code_n, err_code_q;
  board_t     snap;

  board_regfile u_shadow (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_sq  (wr_sq),
    .wr_data(in_data),
    .snap   (snap)
  );

  always_comb begin
    state_n    = state;
    count_n    = count;
    wr_en      = 1'b0;
    wr_sq      = beat_to_sq(count[5:0]);
    commit     = 1'b0;
    err        = 1'b0;
    err_code_n = ERR_NONE;
    if (in_valid) begin
      // A sop anywhere starts a fresh packet; only mid-LOAD is it an error.
      if (in_sop) begin
        wr_en   = 1'b1;
        wr_sq   = beat_to_sq(6'd0);
        count_n = 7'd1;
        state_n = in_eop ? ST_DROP : ST_LOAD;
        if (state == ST_LOAD) begin
          err        = 1'b1;
          err_code_n = ERR_SOP_MID;
        end
      end else begin
        case (state)
          ST_LOAD: begin
            if (count == 7'(NUM_SQ)) begin
              err        = 1'b1;
              err_code_n = ERR_LONG;
              state_n    = in_eop ? ST_IDLE : ST_DROP;
              count_n    = '0;
            end else if (in_eop) begin
              wr_en   = 1'b1;
              state_n = ST_IDLE;
              count_n = '0;
              if (count == 7'(NUM_SQ - 1)) begin
                commit = 1'b1;
              end else begin
                err        = 1'b1;
                err_code_n = ERR_SHORT;
              end
            end else begin
              wr_en   = 1'b1;
              count_n = count + 7'd1;
            end
          end
          ST_DROP: begin
            if (in_eop) begin
              state_n = ST_IDLE;
              count_n = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= '0;
      o_board       <= '0;
      o_board_valid <= 1'b0;
      o_err         <= 1'b0;
      err_code_q    <= ERR_NONE;
      o_sq_piece    <= PIECE_EMPTY;
    end else begin
      state         <= state_n;
      count         <= count_n;
      o_board_valid <= commit;
      o_err         <= err;
      if (commit) o_board <= snap;
      if (err) err_code_q <= err_code_n;
      // Reads the board as it stands before this edge's commit.
      o_sq_piece    <= o_board[{i_sq_addr, 2'b00} +: 4];
    end
  end

  assign o_err_code = err_code_q;
  assign o_busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_fen_board_load.sv
// Directed bench for fen_board_load: table of packet scenarios plus hand sequences
// for back-to-back commits, the square read port and mid-packet reset.
module tb_fen_board_load;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   in_data;
  logic         in_sop;
  logic         in_eop;
  logic [255:0] o_board;
  logic         o_board_valid;
  logic         o_err;
  logic [1:0]   o_err_code;
  logic         o_busy;
  logic [5:0]   i_sq_addr;
  logic [3:0]   o_sq_piece;

  fen_board_load dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .o_board      (o_board),
    .o_board_valid(o_board_valid),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_busy       (o_busy),
    .i_sq_addr    (i_sq_addr),
    .o_sq_piece   (o_sq_piece)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    n;
    int    sop2;
    int    seed;
    int    commit;
    int    err;
    int    code;
    int    err_beat;
  } vec_t;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int n_commit, n_err, err_beat, commit_beat;
  logic [255:0] model;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Start-position codes: white P..K = 1..6, black = white + 8.
  function automatic logic [3:0] pdat(input int seed, input int k);
    logic [3:0] back_b [8] = '{4'd12, 4'd10, 4'd11, 4'd13, 4'd14, 4'd11, 4'd10, 4'd12};
    logic [3:0] back_w [8] = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    if (seed >= 0) return 4'((seed * 7 + k * 5 + 1) % 16);
    if (k < 8)  return back_b[k];
    if (k < 16) return 4'd9;
    if (k < 48) return 4'd0;
    if (k < 56) return 4'd1;
    return back_w[k - 56];
  endfunction

  function automatic logic [255:0] exp_board(input int seed);
    logic [255:0] b = '0;
    for (int j = 0; j < 64; j++) b[4 * (j ^ 56) +: 4] = pdat(seed, j);
    return b;
  endfunction

  task automatic beat(input logic v, input logic [3:0] d, input logic s, input logic e);
    in_valid = v; in_data = d; in_sop = s; in_eop = e;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send_pkt(input int n, input int sop2, input int seed);
    n_commit = 0; n_err = 0; err_beat = -1; commit_beat = -1;
    for (int k = 0; k < n; k++) begin
      int rel;
      rel = (sop2 >= 0 && k >= sop2) ? k - sop2 : k;
      beat(1'b1, pdat(seed, rel), (k == 0) || (k == sop2), k == n - 1);
      n_commit += int'(o_board_valid);
      n_err    += int'(o_err);
      if (o_err && err_beat < 0) err_beat = k;
      if (o_board_valid) commit_beat = k;
    end
  endtask

  vec_t vecs [5];

  initial begin
    int c1, c2;
    logic [255:0] b9, b10;
    vecs[0] = '{"start",    64, -1, -1, 1, 0, 0, -1};
    vecs[1] = '{"short",    41, -1,  3, 0, 1, 1, 40};
    vecs[2] = '{"long",     70, -1,  4, 0, 1, 2, 64};
    vecs[3] = '{"post_long",64, -1,  5, 1, 0, 0, -1};
    vecs[4] = '{"sop_mid",  84, 20,  7, 1, 1, 3, 20};

    rst = 1'b1; i_sq_addr = 6'd4;
    beat(1'b0, 4'd0, 1'b0, 1'b0);
    beat(1'b0, 4'd0, 1'b0, 1'b0);
    chk("rst_board", o_board, '0);
    chk("rst_valid", 256'(o_board_valid), 256'(0));
    chk("rst_err", 256'(o_err), 256'(0));
    chk("rst_code", 256'(o_err_code), 256'(0));
    chk("rst_busy", 256'(o_busy), 256'(0));
    chk("rst_sq", 256'(o_sq_piece), 256'(0));
    rst = 1'b0;
    // Beats without sop in IDLE are ignored.
    beat(1'b1, 4'd7, 1'b0, 1'b1);
    chk("idle_ignore_busy", 256'(o_busy), 256'(0));
    chk("idle_ignore_err", 256'(o_err), 256'(0));
    model = '0;

    for (int i = 0; i < 5; i++) begin
      send_pkt(vecs[i].n, vecs[i].sop2, vecs[i].seed);
      if (vecs[i].commit != 0) model = exp_board(vecs[i].seed);
      beat(1'b0, 4'd0, 1'b0, 1'b0);
      n_commit += int'(o_board_valid);
      n_err    += int'(o_err);
      chk({vecs[i].name, "_commits"}, 256'(n_commit), 256'(vecs[i].commit));
      chk({vecs[i].name, "_errs"}, 256'(n_err), 256'(vecs[i].err));
      chk({vecs[i].name, "_board"}, o_board, model);
      chk({vecs[i].name, "_busy"}, 256'(o_busy), 256'(0));
      if (vecs[i].commit != 0)
        chk({vecs[i].name, "_commit_latency"}, 256'(commit_beat), 256'(vecs[i].n - 1));
      if (vecs[i].err != 0) begin
        chk({vecs[i].name, "_err_beat"}, 256'(err_beat), 256'(vecs[i].err_beat));
        chk({vecs[i].name, "_code"}, 256'(o_err_code), 256'(vecs[i].code));
      end
      if (i == 0) begin
        chk("start_a1_rook", 256'(o_board[3:0]), 256'(4));
        chk("start_e8_king", 256'(o_board[243:240]), 256'(14));
        chk("start_empty_mid", 256'(o_board[191:64]), 256'(0));
      end
    end

    // Back-to-back packets, zero gap; square 4 (e1) read port follows each commit.
    b9 = exp_board(9); b10 = exp_board(10);
    c1 = -1; c2 = -1;
    for (int k = 0; k < 128; k++) begin
      int s;
      s = (k < 64) ? 9 : 10;
      beat(1'b1, pdat(s, k % 64), (k % 64) == 0, (k % 64) == 63);
      if (o_board_valid) begin
        if (c1 < 0) c1 = cyc; else c2 = cyc;
      end
      if (o_err) chk("b2b_no_err", 256'(o_err), 256'(0));
      if (k == 63)  chk("b2b_sq_precommit", 256'(o_sq_piece), 256'(model[19:16]));
      if (k == 64)  chk("b2b_sq_first", 256'(o_sq_piece), 256'(b9[19:16]));
      if (k == 127) chk("b2b_sq_pre_second", 256'(o_sq_piece), 256'(b9[19:16]));
    end
    beat(1'b0, 4'd0, 1'b0, 1'b0);
    chk("b2b_sq_second", 256'(o_sq_piece), 256'(b10[19:16]));
    chk("b2b_spacing", 256'(c2 - c1), 256'(64));
    chk("b2b_board", o_board, b10);

    // Reset at beat 30: everything clears, the tail is ignored silently.
    for (int k = 0; k < 30; k++) beat(1'b1, pdat(11, k), k == 0, 1'b0);
    rst = 1'b1;
    beat(1'b1, pdat(11, 30), 1'b0, 1'b0);
    chk("mid_rst_board", o_board, '0);
    chk("mid_rst_flags", 256'({o_board_valid, o_err, o_err_code, o_busy}), 256'(0));
    chk("mid_rst_sq", 256'(o_sq_piece), 256'(0));
    rst = 1'b0;
    n_commit = 0; n_err = 0;
    for (int k = 31; k < 64; k++) begin
      beat(1'b1, pdat(11, k), 1'b0, k == 63);
      n_commit += int'(o_board_valid);
      n_err    += int'(o_err);
    end
    beat(1'b0, 4'd0, 1'b0, 1'b0);
    chk("tail_no_commit", 256'(n_commit), 256'(0));
    chk("tail_no_err", 256'(n_err), 256'(0));
    chk("tail_board", o_board, '0);
    chk("tail_busy", 256'(o_busy), 256'(0));

    send_pkt(64, -1, 12);
    beat(1'b0, 4'd0, 1'b0, 1'b0);
    chk("recover_board", o_board, exp_board(12));
    chk("recover_commits", 256'(n_commit), 256'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
